// File: rtl/cpu_structs_pkg.sv
// rtl/cpu_structs_pkg.sv - shared CPU pipeline types
package cpu_structs_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    WAIT_DN = 2'd2
  } STAGE_CTRL_ST_T;

endpackage

// File: rtl/logic_params_pkg.sv
// rtl/logic_params_pkg.sv - shared boolean constants
package logic_params_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

endpackage

// File: rtl/stage_ctrl.sv
// rtl/stage_ctrl.sv - flushable multi-cycle stage sequencer between two pipes
module stage_ctrl
  import logic_params_pkg::*;
  import cpu_structs_pkg::*;
#(
  parameter type T_IN  = logic,
  parameter type T_OUT = logic,
  parameter int  LAT_W = 4
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             flush_in,
  input  logic             up_valid_in,
  input  T_IN              up_data_in,
  output logic             up_read_out,
  input  logic [LAT_W-1:0] op_lat_in,
  output T_IN              cur_data_out,
  input  T_OUT             exec_result_in,
  input  logic             dn_full_in,
  output logic             dn_write_out,
  output T_OUT             dn_data_out,
  output logic             busy_out
);

  STAGE_CTRL_ST_T   state;
  logic [LAT_W-1:0] cnt;
  T_IN              cur_q;
  T_OUT             res_q;
  logic             done_ok;
  logic             pop;

  always_comb begin
    done_ok     = FALSE;
    dn_data_out = res_q;
    case (state)
      EXEC: begin
        if (cnt == '0) begin
          dn_data_out = exec_result_in;
          if (!dn_full_in) done_ok = TRUE;
        end
      end
      WAIT_DN: begin
        if (!dn_full_in) done_ok = TRUE;
      end
      default: ;
    endcase
    // Reset is asynchronous, so the combinational handshakes must drop with it too.
    if (flush_in || !reset_in) done_ok = FALSE;
  end

  assign pop          = reset_in & up_valid_in & ~flush_in & ((state == IDLE) | done_ok);
  assign up_read_out  = pop;
  assign dn_write_out = done_ok;
  assign cur_data_out = cur_q;
  assign busy_out     = (state != IDLE);

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state <= IDLE;
      cnt   <= '0;
      cur_q <= '0;
      res_q <= '0;
    end else if (flush_in) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (pop) begin
      cur_q <= up_data_in;
      cnt   <= op_lat_in;
      state <= EXEC;
    end else if (done_ok) begin
      state <= IDLE;
    end else if (state == EXEC) begin
      // Completion without done_ok means the downstream pipe is full: latch the result.
      if (cnt != '0) begin
        cnt <= cnt - LAT_W'(1);
      end else begin
        res_q <= exec_result_in;
        state <= WAIT_DN;
      end
    end
  end

endmodule

// File: tb/tb_stage_ctrl.sv
// tb/tb_stage_ctrl.sv - self-checking bench for stage_ctrl
module tb_stage_ctrl;

  typedef logic [7:0] byte_t;

  logic       clk_in = 1'b0;
  logic       reset_in;
  logic       flush_in = 1'b0;
  logic       up_valid_in = 1'b0;
  byte_t      up_data_in = 8'h00;
  logic       up_read_out;
  logic [3:0] op_lat_in = 4'd0;
  byte_t      cur_data_out;
  byte_t      exec_result_in;
  logic       dn_full_in = 1'b0;
  logic       dn_write_out;
  byte_t      dn_data_out;
  logic       busy_out;

  logic       res_from_cur = 1'b1;
  byte_t      res_rand = 8'h00;

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  byte_t wr_data[$];
  int    wr_cyc[$];

  // Model state: item held, cycles left until completion, stalled result.
  logic  m_have = 1'b0;
  int    m_rem = 0;
  byte_t m_cur = 8'h00;
  logic  m_stalled = 1'b0;
  byte_t m_saved = 8'h00;

  always #5 clk_in = ~clk_in;

  assign exec_result_in = res_from_cur ? (cur_data_out ^ 8'h33) : res_rand;

  stage_ctrl #(.T_IN(byte_t), .T_OUT(byte_t), .LAT_W(4)) dut (
    .clk_in(clk_in),
    .reset_in(reset_in),
    .flush_in(flush_in),
    .up_valid_in(up_valid_in),
    .up_data_in(up_data_in),
    .up_read_out(up_read_out),
    .op_lat_in(op_lat_in),
    .cur_data_out(cur_data_out),
    .exec_result_in(exec_result_in),
    .dn_full_in(dn_full_in),
    .dn_write_out(dn_write_out),
    .dn_data_out(dn_data_out),
    .busy_out(busy_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cycle, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    up_valid_in = 1'b0;
    flush_in    = 1'b0;
    dn_full_in  = 1'b0;
    while (busy_out && n < 50) begin
      tick();
      n++;
    end
    chk("drain_idle", busy_out, 1'b0);
  endtask

  task automatic clear_log();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  always @(negedge clk_in) begin
    logic  e_wr;
    logic  e_rd;
    cycle++;
    if (!reset_in) begin
      chk("rst_up_read", up_read_out, 1'b0);
      chk("rst_dn_write", dn_write_out, 1'b0);
      chk("rst_dn_data", dn_data_out, 8'h00);
      chk("rst_cur_data", cur_data_out, 8'h00);
      chk("rst_busy", busy_out, 1'b0);
      m_have = 1'b0; m_rem = 0; m_cur = 8'h00; m_stalled = 1'b0; m_saved = 8'h00;
    end else begin
      e_wr = m_have && (m_rem == 0) && !dn_full_in && !flush_in;
      e_rd = up_valid_in && !flush_in && (!m_have || e_wr);
      chk("up_read", up_read_out, e_rd);
      chk("dn_write", dn_write_out, e_wr);
      chk("busy", busy_out, m_have);
      if (m_have) chk("cur_data", cur_data_out, m_cur);
      if (m_stalled) chk("wait_data", dn_data_out, m_saved);
      if (e_wr) chk("wr_data", dn_data_out, m_stalled ? m_saved : exec_result_in);
      if (dn_write_out) begin
        wr_data.push_back(dn_data_out);
        wr_cyc.push_back(cycle);
      end
      if (flush_in) begin
        m_have = 1'b0; m_rem = 0; m_stalled = 1'b0;
      end else begin
        if (m_have && m_rem > 0) begin
          m_rem--;
        end else if (m_have && !e_wr && !m_stalled) begin
          m_stalled = 1'b1;
          m_saved   = exec_result_in;
        end
        if (e_wr) begin
          m_have = 1'b0; m_stalled = 1'b0;
        end
        if (e_rd) begin
          m_have = 1'b1; m_rem = int'(op_lat_in); m_cur = up_data_in; m_stalled = 1'b0;
        end
      end
    end
  end

  initial begin
    int wr_k;
    int busy_n;
    int n_ab;
    byte_t wr_d;

    // Reset with a valid upstream item waiting.
    reset_in = 1'b1; up_valid_in = 1'b1; up_data_in = 8'h11; op_lat_in = 4'd3;
    #1 reset_in = 1'b0;
    #1;
    chk("reset_up_read", up_read_out, 1'b0);
    chk("reset_dn_write", dn_write_out, 1'b0);
    chk("reset_dn_data", dn_data_out, 8'h00);
    chk("reset_cur", cur_data_out, 8'h00);
    chk("reset_busy", busy_out, 1'b0);
    tick(); tick();
    chk("reset_hold_read", up_read_out, 1'b0);
    reset_in = 1'b1;
    #1;
    chk("first_pop_ready", up_read_out, 1'b1);

    // Latency: 0x11 with 3 extra cycles, result 0x22.
    tick();
    up_valid_in = 1'b0;
    chk("lat_cur", cur_data_out, 8'h11);
    wr_k = -1; busy_n = 0; wr_d = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (busy_out) busy_n++;
      if (dn_write_out && wr_k < 0) begin
        wr_k = k;
        wr_d = dn_data_out;
      end
      tick();
    end
    chk("lat_cycles", wr_k, 3);
    chk("lat_data", wr_d, 8'h22);
    chk("lat_busy_cycles", busy_n, 4);

    // Streaming: 8 items, zero latency, no backpressure.
    clear_log();
    op_lat_in = 4'd0; up_valid_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      up_data_in = byte_t'(8'h40 + i);
      tick();
    end
    drain();
    chk("stream_count", wr_data.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < wr_data.size()) begin
        chk("stream_data", wr_data[i], byte_t'(8'h40 + i) ^ 8'h33);
        chk("stream_cycle", wr_cyc[i], wr_cyc[0] + i);
      end
    end

    // Backpressure: result 0xAB held for 5 full cycles.
    op_lat_in = 4'd1; up_data_in = 8'h98; up_valid_in = 1'b1;
    tick();
    up_valid_in = 1'b0;
    tick();
    clear_log();
    dn_full_in = 1'b1; up_valid_in = 1'b1; up_data_in = 8'h55; op_lat_in = 4'd0;
    #1;
    chk("bp_completion_data", dn_data_out, 8'hAB);
    for (int i = 0; i < 5; i++) begin
      chk("bp_no_write", dn_write_out, 1'b0);
      chk("bp_no_pop", up_read_out, 1'b0);
      tick();
      res_from_cur = 1'b0;
      res_rand = byte_t'($urandom);
      chk("bp_busy", busy_out, 1'b1);
      chk("bp_cur_stable", cur_data_out, 8'h98);
    end
    dn_full_in = 1'b0;
    #1;
    chk("bp_release_write", dn_write_out, 1'b1);
    chk("bp_release_data", dn_data_out, 8'hAB);
    chk("bp_release_pop", up_read_out, 1'b1);
    tick();
    up_valid_in = 1'b0; res_from_cur = 1'b1;
    drain();
    n_ab = 0;
    foreach (wr_data[i]) if (wr_data[i] == 8'hAB) n_ab++;
    chk("bp_single_write", n_ab, 1);
    chk("bp_total_writes", wr_data.size(), 2);

    // Flush while two extra cycles remain.
    op_lat_in = 4'd3; up_data_in = 8'h10; up_valid_in = 1'b1;
    tick();
    up_valid_in = 1'b0;
    tick();
    clear_log();
    flush_in = 1'b1; up_valid_in = 1'b1; up_data_in = 8'h20; op_lat_in = 4'd0;
    #1;
    chk("flush_no_read", up_read_out, 1'b0);
    chk("flush_no_write", dn_write_out, 1'b0);
    tick();
    flush_in = 1'b0;
    #1;
    chk("flush_idle", busy_out, 1'b0);
    chk("flush_next_pop", up_read_out, 1'b1);
    tick();
    drain();
    chk("flush_write_count", wr_data.size(), 1);
    if (wr_data.size() > 0) chk("flush_next_data", wr_data[0], 8'h13);

    // Asynchronous reset while stalled in WAIT_DN.
    op_lat_in = 4'd0; up_data_in = 8'h77; up_valid_in = 1'b1;
    tick();
    up_valid_in = 1'b0; dn_full_in = 1'b1;
    tick(); tick();
    clear_log();
    chk("arst_pre_busy", busy_out, 1'b1);
    #2 reset_in = 1'b0;
    #1;
    chk("arst_busy", busy_out, 1'b0);
    chk("arst_write", dn_write_out, 1'b0);
    chk("arst_dn_data", dn_data_out, 8'h00);
    chk("arst_cur", cur_data_out, 8'h00);
    chk("arst_read", up_read_out, 1'b0);
    dn_full_in = 1'b0;
    tick();
    reset_in = 1'b1;
    tick();
    drain();
    chk("arst_no_write", wr_data.size(), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      up_valid_in  = ($urandom_range(0, 3) != 0);
      up_data_in   = byte_t'($urandom);
      op_lat_in    = ($urandom_range(0, 15) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
      dn_full_in   = ($urandom_range(0, 2) == 0);
      flush_in     = ($urandom_range(0, 39) == 0);
      res_from_cur = ($urandom_range(0, 1) == 0);
      res_rand     = byte_t'($urandom);
      tick();
    end
    drain();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL global_timeout cycle=%0d got=running expected=finished", cycle);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stage_ctrl.md
# stage_ctrl

Generic pipeline-stage sequencer that sits between two `pipe` buffers. It is the reader of the upstream pipe and the writer of the downstream pipe. It pops one item when the upstream pipe is valid and presents it to external stage execution logic. It holds the item for a per-item number of extra cycles, then pushes the execution result into the downstream pipe, stalling while that pipe is full. It gives every multi-cycle stage (MUL/DIV, memory) one common, flushable handshake.

## Interface
- `T_IN`, default `logic`: item type read from the upstream pipe.
- `T_OUT`, default `logic`: result type written to the downstream pipe.
- `LAT_W`, default 4: width of the per-item extra-latency count.
- `clk_in` in 1: single clock, rising edge.
- `reset_in` in 1: asynchronous, active-low reset.
- `flush_in` in 1: discard any held item; dominates all other inputs.
- `up_valid_in` in 1: upstream pipe `valid_out`.
- `up_data_in` in `T_IN`: upstream pipe `data_out`.
- `up_read_out` out 1: upstream pipe `read_in`; combinational.
- `op_lat_in` in `LAT_W`: extra execute cycles for the item on `up_data_in`; sampled with the pop.
- `cur_data_out` out `T_IN`: registered item under execution.
- `exec_result_in` in `T_OUT`: result from external execution logic; valid on the completion cycle.
- `dn_full_in` in 1: downstream pipe `full_out`.
- `dn_write_out` out 1: downstream pipe `write_in`; combinational.
- `dn_data_out` out `T_OUT`: downstream pipe `data_in`.
- `busy_out` out 1: the state is not IDLE.

## Operation
- There are 3 states: IDLE, EXEC and WAIT_DN. The registers are `state`, `cnt` (`LAT_W` bits), `cur_q` (`T_IN`) and `res_q` (`T_OUT`).
- **Pop condition.** `pop = up_valid_in & !flush_in & (state==IDLE | done_ok)`.
  - `up_read_out = pop`.
  - On a pop, `cur_q <= up_data_in`, `cnt <= op_lat_in` and the next state is EXEC.
- **EXEC.**
  - If `cnt != 0`: decrement `cnt`. No write.
  - If `cnt == 0` (completion): `dn_data_out = exec_result_in`.
    - If `!dn_full_in`, then `dn_write_out = 1` (this is `done_ok`). The next state is EXEC on a pop, otherwise IDLE.
    - If `dn_full_in`, then `res_q <= exec_result_in` and the next state is WAIT_DN.
- **WAIT_DN.** `dn_data_out = res_q` and `dn_write_out = !dn_full_in` (this is `done_ok`). The next state follows the same rule as at EXEC completion. Otherwise stay in WAIT_DN.
- **IDLE.** `dn_data_out = res_q`. No write.
- **Flush.** When `flush_in = 1`:
  - `up_read_out = 0` and `dn_write_out = 0` in that cycle.
  - The next state is IDLE and `cnt <= 0`.
  - `cur_q` and `res_q` keep their values; they are don't-care.
- `cnt` never wraps. It decrements only while it is nonzero in EXEC.
- `cur_data_out = cur_q`. `busy_out = (state != IDLE)`.
- `dn_full_in` must not depend combinationally on `dn_write_out`. The `pipe` block's `full_out` depends only on its own read, so this holds.

## Timing
- **Reset (`reset_in = 0`).** Effective immediately, without waiting for a clock edge:
  - `state = IDLE`, `cnt = 0`, `cur_q = '0`, `res_q = '0`.
  - Outputs: `up_read_out = 0`, `dn_write_out = 0`, `dn_data_out = '0`, `cur_data_out = '0`, `busy_out = 0`.
  - A mid-operation reset drops the held item with no downstream write.
- **Latency.** An item popped at edge t is written at edge t + 1 + `op_lat_in`, provided the downstream pipe is not full.
- **Throughput.** With `op_lat_in = 0`, no backpressure and a continuously valid upstream, the block sustains 1 item per cycle. The pop and the write coincide in the same cycle.
- **Backpressure.** Each full cycle adds exactly 1 cycle of latency. No item is lost or duplicated. `cur_data_out` stays stable while in WAIT_DN.
- `up_read_out` is asserted only when `up_valid_in = 1`.

## Structure
- The state enum `STAGE_CTRL_ST_T` (IDLE, EXEC, WAIT_DN) lives in `cpu_structs_pkg`.
- `TRUE`/`FALSE` come from `logic_params_pkg`.
- The block is one module. The down-counter stays inline; no sub-module is warranted.
- The intended instantiation is upstream `pipe` → `stage_ctrl` → downstream `pipe`.

## Test plan
- **Reset values.** Hold reset low with `up_valid_in = 1`. Required: every output is 0, and after release the first pop happens at the next edge.
- **Latency.** Pop `0x11` with `op_lat_in = 3` and `exec_result_in = 0x22`. Required: `dn_write_out = 1` with `0x22` exactly 4 cycles after the pop. `busy_out` is high for 4 cycles.
- **Streaming.** Stream 8 items with `op_lat_in = 0` and no backpressure. Required: 8 consecutive writes, one per cycle, in order.
- **Backpressure.** Hold `dn_full_in = 1` for 5 cycles at completion of `0xAB`. Required: state is WAIT_DN, there is no pop, and a single write of `0xAB` occurs on the first not-full cycle.
- **Flush in EXEC.** Assert `flush_in` in EXEC with `cnt = 2`. Required: no write ever occurs for that item, the state is IDLE next cycle, and the next valid item pops and completes normally.
- **Asynchronous reset mid-operation.** Deassert `reset_in` asynchronously mid-cycle while in WAIT_DN. Required: outputs go to 0 before the next edge, and no write of the held item occurs.
